// File: rtl/fproc_rr_sched.sv
// rtl/fproc_rr_sched.sv - round-robin scheduler sharing one fproc LUT backend among N_CORES cores
//
// Purpose: queues at most one fproc request per core, grants the shared LUT backend to one
// pending core at a time in round-robin order, and returns the result plus a one-cycle ready
// pulse to the originating core. A silent backend is cut off after TIMEOUT wait cycles.
//
// Ports:
//   clk           clock
//   reset         synchronous, active-low reset
//   fproc_id      per-core request id, sampled with fproc_enable
//   fproc_enable  per-core request strobe (one-cycle pulse)
//   fproc_data    per-core result, held until that core's next delivery
//   fproc_ready   per-core one-cycle result-valid pulse
//   lut_valid     backend request strobe (one cycle)
//   lut_id        backend request id (held after issue)
//   lut_core      index of the granted core (held after issue)
//   lut_ready     backend response strobe, honoured only while waiting
//   lut_data      backend response data, valid with lut_ready
//   busy          scheduler active or any request pending
//   err_overrun   sticky per core: enable arrived while that core was already pending
//   err_timeout   sticky: backend failed to answer within TIMEOUT cycles
module fproc_rr_sched #(
    parameter int N_CORES        = 5,
    parameter int DATA_WIDTH     = 32,
    parameter int FPROC_ID_WIDTH = 8,
    parameter int TIMEOUT        = 255,
    localparam int CW            = (N_CORES > 1) ? $clog2(N_CORES) : 1
) (
    input  logic                                         clk,
    input  logic                                         reset,
    input  logic [N_CORES-1:0][FPROC_ID_WIDTH-1:0]       fproc_id,
    input  logic [N_CORES-1:0]                           fproc_enable,
    output logic [N_CORES-1:0][DATA_WIDTH-1:0]           fproc_data,
    output logic [N_CORES-1:0]                           fproc_ready,
    output logic                                         lut_valid,
    output logic [FPROC_ID_WIDTH-1:0]                    lut_id,
    output logic [CW-1:0]                                lut_core,
    input  logic                                         lut_ready,
    input  logic [DATA_WIDTH-1:0]                        lut_data,
    output logic                                         busy,
    output logic [N_CORES-1:0]                           err_overrun,
    output logic                                         err_timeout
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_RESPOND = 2'd3
    } state_t;

    state_t                                    r_state;
    state_t                                    w_next_state;

    logic [N_CORES-1:0]                        r_pending;
    logic [N_CORES-1:0][FPROC_ID_WIDTH-1:0]    r_id_q;
    logic [N_CORES-1:0][DATA_WIDTH-1:0]        r_data;
    logic [CW-1:0]                             r_grant;
    logic [FPROC_ID_WIDTH-1:0]                 r_lut_id;
    logic [CW-1:0]                             r_rr_last;
    logic [15:0]                               r_timer;
    logic [N_CORES-1:0]                        r_err_overrun;
    logic                                      r_err_timeout;

    logic                                      w_grant_found;
    logic [CW-1:0]                             w_grant_idx;
    logic [CW:0]                               w_cand;
    logic [N_CORES-1:0]                        w_respond;
    logic                                      w_timeout;

    // Search starts one past the last served core so the most recent winner is considered last.
    // The extra bit on w_cand holds the unwrapped sum before the modulo-N_CORES fold.
    always_comb begin
        w_grant_found = 1'b0;
        w_grant_idx   = '0;
        w_cand        = '0;
        for (int k = 1; k <= N_CORES; k++) begin
            w_cand = {1'b0, r_rr_last} + (CW+1)'(k);
            if (w_cand >= (CW+1)'(N_CORES)) begin
                w_cand = w_cand - (CW+1)'(N_CORES);
            end
            if (!w_grant_found && r_pending[w_cand[CW-1:0]]) begin
                w_grant_found = 1'b1;
                w_grant_idx   = w_cand[CW-1:0];
            end
        end
    end

    always_comb begin
        w_respond = '0;
        if (r_state == ST_RESPOND) begin
            w_respond[r_grant] = 1'b1;
        end
    end

    // Last permitted wait cycle without an answer: leave WAIT so RESPOND lands TIMEOUT
    // cycles after WAIT entry.
    assign w_timeout = (r_state == ST_WAIT) && !lut_ready && (r_timer == 16'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:    if (w_grant_found) w_next_state = ST_ISSUE;
            ST_ISSUE:   w_next_state = ST_WAIT;
            ST_WAIT:    if (lut_ready || w_timeout) w_next_state = ST_RESPOND;
            ST_RESPOND: w_next_state = ST_IDLE;
            default:    w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pending     <= '0;
            r_id_q        <= '0;
            r_data        <= '0;
            r_grant       <= '0;
            r_lut_id      <= '0;
            r_rr_last     <= CW'(N_CORES - 1);
            r_timer       <= '0;
            r_err_overrun <= '0;
            r_err_timeout <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_found) begin
                        r_grant  <= w_grant_idx;
                        r_lut_id <= r_id_q[w_grant_idx];
                    end
                end
                ST_ISSUE: begin
                    r_timer <= '0;
                end
                ST_WAIT: begin
                    // Result is written on the way into RESPOND so it is already
                    // visible in the same cycle as the ready pulse.
                    if (lut_ready) begin
                        r_data[r_grant] <= lut_data;
                    end else if (w_timeout) begin
                        r_data[r_grant] <= '0;
                        r_err_timeout   <= 1'b1;
                    end else begin
                        r_timer <= r_timer + 16'd1;
                    end
                end
                ST_RESPOND: begin
                    r_rr_last <= r_grant;
                end
                default: ;
            endcase

            // A new enable in a core's own RESPOND cycle is accepted: setting pending
            // takes priority over the completion clearing it.
            for (int i = 0; i < N_CORES; i++) begin
                if (fproc_enable[i] && (!r_pending[i] || w_respond[i])) begin
                    r_pending[i] <= 1'b1;
                    r_id_q[i]    <= fproc_id[i];
                end else if (fproc_enable[i]) begin
                    r_err_overrun[i] <= 1'b1;
                end else if (w_respond[i]) begin
                    r_pending[i] <= 1'b0;
                end
            end
        end
    end

    assign fproc_data  = r_data;
    assign fproc_ready = w_respond;
    assign lut_valid   = (r_state == ST_ISSUE);
    assign lut_id      = r_lut_id;
    assign lut_core    = r_grant;
    assign busy        = (r_state != ST_IDLE) || (|r_pending);
    assign err_overrun = r_err_overrun;
    assign err_timeout = r_err_timeout;

endmodule

// File: tb/tb_fproc_rr_sched.sv
// tb/tb_fproc_rr_sched.sv - scoreboard testbench for fproc_rr_sched
module tb_fproc_rr_sched;

    localparam int N  = 5;
    localparam int DW = 32;
    localparam int IW = 8;
    localparam int TO = 8;
    localparam int CW = 3;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [N-1:0][IW-1:0]   fproc_id;
    logic [N-1:0]           fproc_enable;
    logic [N-1:0][DW-1:0]   fproc_data;
    logic [N-1:0]           fproc_ready;
    logic                   lut_valid;
    logic [IW-1:0]          lut_id;
    logic [CW-1:0]          lut_core;
    logic                   lut_ready;
    logic [DW-1:0]          lut_data;
    logic                   busy;
    logic [N-1:0]           err_overrun;
    logic                   err_timeout;

    always #5 clk = ~clk;

    fproc_rr_sched #(
        .N_CORES        (N),
        .DATA_WIDTH     (DW),
        .FPROC_ID_WIDTH (IW),
        .TIMEOUT        (TO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .fproc_id     (fproc_id),
        .fproc_enable (fproc_enable),
        .fproc_data   (fproc_data),
        .fproc_ready  (fproc_ready),
        .lut_valid    (lut_valid),
        .lut_id       (lut_id),
        .lut_core     (lut_core),
        .lut_ready    (lut_ready),
        .lut_data     (lut_data),
        .busy         (busy),
        .err_overrun  (err_overrun),
        .err_timeout  (err_timeout)
    );

    typedef struct {
        int          core;
        logic [7:0]  id;
    } iss_t;

    typedef struct {
        int          core;
        logic [31:0] data;
    } rsp_t;

    iss_t        exp_iss[$];
    rsp_t        exp_rsp[$];
    logic [31:0] shadow [N];

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int n_issue     = 0;
    int n_ready     = 0;
    int iss_cyc     = 0;
    int rdy_cyc     = 0;
    bit be_silent   = 1'b0;
    bit late_req    = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] be_data(input logic [7:0] id);
        if (id == 8'h15) return 32'hDEADBEEF;
        return {id, ~id, 8'hA5, id ^ 8'h3C};
    endfunction

    function automatic void push_txn(input int core, input logic [7:0] id, input bit timed_out);
        iss_t i;
        rsp_t r;
        i.core = core;
        i.id   = id;
        r.core = core;
        r.data = timed_out ? 32'h0 : be_data(id);
        exp_iss.push_back(i);
        exp_rsp.push_back(r);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Backend: answers one cycle after lut_valid unless silenced; late_req forces a stray strobe.
    initial begin
        logic [7:0] id;
        lut_ready = 1'b0;
        lut_data  = '0;
        forever begin
            @(negedge clk);
            if (late_req) begin
                late_req = 1'b0;
                @(posedge clk); #1;
                lut_ready = 1'b1;
                lut_data  = 32'hBAD0BAD0;
                @(posedge clk); #1;
                lut_ready = 1'b0;
                lut_data  = '0;
            end else if (lut_valid && !be_silent) begin
                id = lut_id;
                @(posedge clk); #1;
                lut_ready = 1'b1;
                lut_data  = be_data(id);
                @(posedge clk); #1;
                lut_ready = 1'b0;
                lut_data  = '0;
            end
        end
    end

    // Scoreboard monitor
    initial begin
        iss_t e;
        rsp_t r;
        forever begin
            @(negedge clk);
            if (lut_valid) begin
                n_issue++;
                iss_cyc = cyc;
                if (exp_iss.size() == 0) begin
                    check_eq("issue_unexpected", 32'(exp_iss.size()), 32'd1);
                end else begin
                    e = exp_iss.pop_front();
                    check_eq("lut_core", 32'(lut_core), 32'(e.core));
                    check_eq("lut_id", 32'(lut_id), 32'(e.id));
                end
            end
            if (fproc_ready != '0) begin
                n_ready++;
                rdy_cyc = cyc;
                check_eq("ready_onehot", 32'($countones(fproc_ready)), 32'd1);
                if (exp_rsp.size() == 0) begin
                    check_eq("ready_unexpected", 32'(fproc_ready), 32'd0);
                end else begin
                    r = exp_rsp.pop_front();
                    check_eq("ready_core", 32'(fproc_ready), 32'(1 << r.core));
                    check_eq("ready_data", fproc_data[r.core], r.data);
                    shadow[r.core] = r.data;
                    for (int j = 0; j < N; j++) begin
                        if (j != r.core) check_eq("data_hold", fproc_data[j], shadow[j]);
                    end
                end
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        reset        = 1'b0;
        fproc_enable = '0;
        @(posedge clk); #1;
        reset = 1'b1;
        for (int j = 0; j < N; j++) shadow[j] = '0;
    endtask

    task automatic wait_drain(input int budget);
        bit done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk);
            if (exp_rsp.size() == 0 && exp_iss.size() == 0 && !busy) done = 1'b1;
        end
        if (!done) check_eq("drain_timeout", 32'(exp_rsp.size()) + 32'(busy), 32'd0);
    endtask

    task automatic wait_ready(input int core, input int budget);
        bit found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            @(negedge clk);
            if (fproc_ready[core]) found = 1'b1;
        end
        if (!found) check_eq("wait_ready_timeout", 32'(found), 32'd1);
    endtask

    task automatic wait_issue(input int budget);
        bit found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            @(negedge clk);
            if (lut_valid) found = 1'b1;
        end
        if (!found) check_eq("wait_issue_timeout", 32'(found), 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        for (int j = 0; j < N; j++) check_eq({tag, "_data"}, fproc_data[j], 32'd0);
        check_eq({tag, "_ready"}, 32'(fproc_ready), 32'd0);
        check_eq({tag, "_lut_valid"}, 32'(lut_valid), 32'd0);
        check_eq({tag, "_lut_id"}, 32'(lut_id), 32'd0);
        check_eq({tag, "_lut_core"}, 32'(lut_core), 32'd0);
        check_eq({tag, "_busy"}, 32'(busy), 32'd0);
        check_eq({tag, "_err_overrun"}, 32'(err_overrun), 32'd0);
        check_eq({tag, "_err_timeout"}, 32'(err_timeout), 32'd0);
    endtask

    initial begin
        int t_en;
        int prev;
        reset        = 1'b0;
        fproc_id     = '0;
        fproc_enable = '0;
        for (int j = 0; j < N; j++) shadow[j] = '0;
        repeat (3) @(posedge clk);
        do_reset();
        check_all_zero("reset");

        // 1: single request, latency and data routing
        @(posedge clk); #1;
        fproc_id[2]  = 8'h15;
        fproc_enable = 5'b00100;
        t_en = cyc;
        push_txn(2, 8'h15, 1'b0);
        @(posedge clk); #1;
        fproc_enable = '0;
        wait_drain(50);
        check_eq("t1_latency", 32'(rdy_cyc - t_en), 32'd4);

        // 2: fairness, all cores at once then core 0 re-requests
        do_reset();
        @(posedge clk); #1;
        for (int j = 0; j < N; j++) begin
            fproc_id[j] = 8'(j);
            push_txn(j, 8'(j), 1'b0);
        end
        fproc_enable = 5'b11111;
        @(posedge clk); #1;
        fproc_enable = '0;
        wait_ready(0, 50);
        fproc_id[0]  = 8'h40;
        fproc_enable = 5'b00001;
        push_txn(0, 8'h40, 1'b0);
        @(posedge clk); #1;
        fproc_enable = '0;
        wait_drain(200);

        // 3: overrun, then re-request in own RESPOND cycle
        prev = n_issue;
        @(posedge clk); #1;
        fproc_id[1]  = 8'h21;
        fproc_enable = 5'b00010;
        push_txn(1, 8'h21, 1'b0);
        @(posedge clk); #1;
        fproc_id[1] = 8'h2E;
        @(posedge clk); #1;
        fproc_id[1] = 8'h2F;
        @(posedge clk); #1;
        fproc_enable = '0;
        check_eq("t3_overrun", 32'(err_overrun), 32'h2);
        wait_ready(1, 50);
        fproc_id[1]  = 8'h30;
        fproc_enable = 5'b00010;
        push_txn(1, 8'h30, 1'b0);
        @(posedge clk); #1;
        fproc_enable = '0;
        wait_drain(100);
        check_eq("t3_overrun_after", 32'(err_overrun), 32'h2);
        check_eq("t3_issue_count", 32'(n_issue - prev), 32'd2);

        // 4: backend timeout, late response ignored
        be_silent = 1'b1;
        @(posedge clk); #1;
        fproc_id[2]  = 8'h55;
        fproc_enable = 5'b00100;
        push_txn(2, 8'h55, 1'b1);
        @(posedge clk); #1;
        fproc_enable = '0;
        wait_drain(100);
        check_eq("t4_timeout_latency", 32'(rdy_cyc - iss_cyc), 32'(TO + 1));
        check_eq("t4_err_timeout", 32'(err_timeout), 32'd1);
        prev = n_ready;
        late_req = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check_eq("t4_late_ready", 32'(n_ready), 32'(prev));
        check_eq("t4_busy", 32'(busy), 32'd0);
        check_eq("t4_err_sticky", 32'(err_timeout), 32'd1);

        // 5: reset during WAIT, then a normal request from core 3
        @(posedge clk); #1;
        fproc_id[4]  = 8'h66;
        fproc_enable = 5'b10000;
        begin
            iss_t i4;
            i4.core = 4;
            i4.id   = 8'h66;
            exp_iss.push_back(i4);
        end
        @(posedge clk); #1;
        fproc_enable = '0;
        wait_issue(20);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        for (int j = 0; j < N; j++) shadow[j] = '0;
        check_all_zero("t5_reset");
        prev = n_ready;
        late_req = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check_eq("t5_late_ready", 32'(n_ready), 32'(prev));
        be_silent = 1'b0;
        @(posedge clk); #1;
        fproc_id[3]  = 8'h77;
        fproc_enable = 5'b01000;
        push_txn(3, 8'h77, 1'b0);
        @(posedge clk); #1;
        fproc_enable = '0;
        wait_drain(50);
        check_eq("t5_ready_count", 32'(n_ready), 32'(prev + 1));
        check_eq("total_issues", 32'(n_issue), 32'd12);
        check_eq("rsp_queue_empty", 32'(exp_rsp.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
